// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : spi_shift_engine
// Purpose  : Strobe-driven SPI shift engine. A parallel word is loaded and
//            then shifted out one bit per 'shift' strobe. Receive bits are
//            captured on 'sample' strobes and shifted in. After N shifts the
//            received word appears on pdataout and done pulses for a cycle.
// Ports    : clk       - single clock, rising edge
//            n_reset   - asynchronous active-low reset
//            pdatain   - parallel transmit word, captured on an accepted load
//            load      - start request (accepted in IDLE or DONE only)
//            abort     - synchronous cancel, highest priority
//            sample    - one-cycle strobe, capture sdatain into rxbit
//            shift     - one-cycle strobe, advance shift register one bit
//            sdatain   - serial receive data
//            lsb_first - bit order select, sampled on an accepted load
//            sdataout  - current transmit bit (0 in IDLE)
//            pdataout  - last completed received word
//            busy      - high while a transfer is in progress
//            done      - one-cycle completion pulse
// Config   : SPI_SHIFT_ENGINE_LSB_FIRST_EN - when defined, lsb_first selects
//            the bit order; otherwise the order is fixed MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module spi_shift_engine #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [N-1:0] pdatain,
  input  logic         load,
  input  logic         abort,
  input  logic         sample,
  input  logic         shift,
  input  logic         sdatain,
  input  logic         lsb_first,
  output logic         sdataout,
  output logic [N-1:0] pdataout,
  output logic         busy,
  output logic         done
);

  localparam int            CW       = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  shreg;
  logic          rxbit;
  logic [CW-1:0] bitcnt;
  logic          lsb_order;

  logic          load_ok;
  logic          in_bit;
  logic [N-1:0]  shreg_next;

  // Load is only honoured outside a transfer and never alongside abort.
  assign load_ok = load && !abort && (state != ST_ACTIVE);

  // A sample in the same cycle as the shift bypasses rxbit so that a
  // combined sample+shift strobe still shifts in the fresh bit.
  assign in_bit     = sample ? sdatain : rxbit;
  assign shreg_next = lsb_order ? {in_bit, shreg[N-1:1]} : {shreg[N-2:0], in_bit};

  // Transmit bit comes straight off the end of the shift register, so the
  // first bit is on the wire in the cycle right after load.
  assign sdataout = (state == ST_IDLE) ? 1'b0
                  : (lsb_order ? shreg[0] : shreg[N-1]);

`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lsb_order <= 1'b0;
    end else if (load_ok) begin
      lsb_order <= lsb_first;
    end
  end
`else
  logic unused_lsb_first;
  assign unused_lsb_first = lsb_first;
  assign lsb_order        = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      rxbit    <= 1'b0;
      bitcnt   <= '0;
      pdataout <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      // Cancel leaves shreg and pdataout untouched and never raises done.
      state  <= ST_IDLE;
      bitcnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state  <= ST_ACTIVE;
            shreg  <= pdatain;
            bitcnt <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (load) begin
            state  <= ST_ACTIVE;
            shreg  <= pdatain;
            bitcnt <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (sample) begin
            rxbit <= sdatain;
          end
          if (shift) begin
            shreg  <= shreg_next;
            bitcnt <= bitcnt + CW'(1);
            // Completion on the Nth shift; bitcnt stops at N, never wraps.
            if (bitcnt == LAST_BIT) begin
              state    <= ST_DONE;
              pdataout <= shreg_next;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_shift_engine
// Purpose  : Self-checking bench for spi_shift_engine. Expected received words
//            are queued when a full transfer is issued; a monitor pops and
//            compares them on every done pulse. Transmit bit order and
//            received words come from a word-level model of the transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;

  localparam int N = 8;

  logic         clk;
  logic         n_reset;
  logic [N-1:0] pdatain;
  logic         load;
  logic         abort;
  logic         sample;
  logic         shift;
  logic         sdatain;
  logic         lsb_first;
  logic         sdataout;
  logic [N-1:0] pdataout;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_rx;

  spi_shift_engine #(.N(N)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .pdatain   (pdatain),
    .load      (load),
    .abort     (abort),
    .sample    (sample),
    .shift     (shift),
    .sdatain   (sdatain),
    .lsb_first (lsb_first),
    .sdataout  (sdataout),
    .pdataout  (pdataout),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Effective bit order: LSB-first is only honoured when the feature exists.
  function automatic bit eff_lsb(input bit l);
`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
    return l;
`else
    return 1'b0;
`endif
  endfunction

  // i-th bit on the wire for word w in the given order.
  function automatic bit wire_bit(input logic [N-1:0] w, input bit l, input int i);
    return l ? w[i] : w[N-1-i];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [N-1:0] tx, input bit l);
    pdatain   = tx;
    lsb_first = l;
    load      = 1'b1;
    step();
    load      = 1'b0;
    pdatain   = N'($urandom);
    chk("busy_after_load", 32'(busy), 32'd1);
    chk("done_after_load", 32'(done), 32'd0);
    chk("first_bit", 32'(sdataout), 32'(wire_bit(tx, eff_lsb(l), 0)));
  endtask

  // mode 0: sample+shift together; 1: separate cycles; 2: random per bit,
  // with ignored loads thrown in during the transfer.
  task automatic run_bits(input logic [N-1:0] tx, input logic [N-1:0] rx,
                          input bit l, input int nbits, input int mode);
    bit e;
    e = eff_lsb(l);
    for (int i = 0; i < nbits; i++) begin
      bit d;
      bit sep;
      chk($sformatf("tx_bit%0d", i), 32'(sdataout), 32'(wire_bit(tx, e, i)));
      d   = wire_bit(rx, e, i);
      sep = (mode == 2) ? bit'($urandom_range(0, 1)) : (mode == 1);
      if (i == N - 1) begin
        exp_q.push_back(rx);
        last_rx = rx;
      end
      if (sep) begin
        sample  = 1'b1;
        sdatain = d;
        if (mode == 2) begin
          load    = 1'($urandom_range(0, 1));
          pdatain = N'($urandom);
        end
        step();
        sample  = 1'b0;
        load    = 1'b0;
        sdatain = 1'($urandom);
        shift   = 1'b1;
        step();
        shift   = 1'b0;
      end else begin
        sample  = 1'b1;
        shift   = 1'b1;
        sdatain = d;
        step();
        sample  = 1'b0;
        shift   = 1'b0;
      end
    end
    if (nbits == N) begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd0);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: pdataout=0x%0h with no transfer pending at %0t",
                 pdataout, $time);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        if (pdataout !== e) begin
          failures++;
          $display("FAIL rx_word: got 0x%0h expected 0x%0h at %0t", pdataout, e, $time);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] tx;
    logic [N-1:0] rx;
    bit           l;

    n_reset   = 1'b0;
    pdatain   = '0;
    load      = 1'b0;
    abort     = 1'b0;
    sample    = 1'b0;
    shift     = 1'b0;
    sdatain   = 1'b0;
    lsb_first = 1'b0;
    last_rx   = '0;

    repeat (2) step();
    chk("rst_sdataout", 32'(sdataout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pdataout", 32'(pdataout), 32'd0);
    n_reset = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic MSB-first transfer: A5 out, 3C in.
    start(8'hA5, 1'b0);
    run_bits(8'hA5, 8'h3C, 1'b0, N, 0);
    step();
    chk("done_single_cycle", 32'(done), 32'd0);
    chk("idle_sdataout", 32'(sdataout), 32'd0);
    chk("pdataout_hold_3c", 32'(pdataout), 32'h3C);

`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
    start(8'hA5, 1'b1);
    run_bits(8'hA5, 8'h81, 1'b1, N, 0);
    step();
    chk("pdataout_hold_81", 32'(pdataout), 32'h81);
`endif

    // Separate versus combined sample/shift must give the same word.
    tx = N'($urandom);
    start(tx, 1'b0);
    run_bits(tx, 8'h5A, 1'b0, N, 1);
    step();
    start(tx, 1'b0);
    run_bits(tx, 8'h5A, 1'b0, N, 0);
    step();

    // Abort after four shifts.
    start(8'hC3, 1'b0);
    run_bits(8'hC3, 8'h96, 1'b0, 4, 0);
    abort = 1'b1;
    load  = 1'b1;
    shift = 1'b1;
    step();
    abort = 1'b0;
    load  = 1'b0;
    shift = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pdataout", 32'(pdataout), 32'(last_rx));
    step();
    chk("abort_pdataout_hold", 32'(pdataout), 32'(last_rx));
    start(8'h12, 1'b0);
    run_bits(8'h12, 8'hE7, 1'b0, N, 0);
    step();

    // Load in the DONE cycle chains straight into a new transfer.
    start(8'h33, 1'b0);
    run_bits(8'h33, 8'h77, 1'b0, N, 0);
    start(8'hFF, 1'b0);
    run_bits(8'hFF, 8'hE4, 1'b0, N, 0);
    step();

    // Reset in the middle of a transfer.
    start(8'h6B, 1'b0);
    run_bits(8'h6B, 8'h29, 1'b0, 3, 0);
    n_reset = 1'b0;
    #1;
    chk("midrst_sdataout", 32'(sdataout), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pdataout", 32'(pdataout), 32'd0);
    last_rx = '0;
    step();
    n_reset = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      sample  = 1'($urandom);
      shift   = 1'($urandom);
      sdatain = 1'($urandom);
      step();
      chk("idle_strobe_pdataout", 32'(pdataout), 32'(last_rx));
      chk("idle_strobe_busy", 32'(busy), 32'd0);
    end
    sample = 1'b0;
    shift  = 1'b0;
    step();

    // Randomized transfers, mixed strobe timing, back-to-back or spaced.
    for (int t = 0; t < 24; t++) begin
      tx = N'($urandom);
      rx = N'($urandom);
      l  = 1'($urandom);
      start(tx, l);
      run_bits(tx, rx, l, N, 2);
      if ($urandom_range(0, 1) == 1) begin
        step();
        chk("rand_pdataout_hold", 32'(pdataout), 32'(last_rx));
      end
    end

    repeat (3) step();
    chk("pending_words", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
